// File: rtl/vga_fb_arbiter.sv
// Shares one single-port frame-buffer RAM between VGA scan-out reads and a FIFO-buffered pixel writer.
// Writes drain only during blanking; colour and syncs are re-aligned to the registered RAM read latency.
module vga_fb_arbiter #(
  parameter int H_DISPLAY  = 256,
  parameter int V_DISPLAY  = 480,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [15:0]       drop_count,
  output logic [2:0]        fifo_level
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [2:0] LVL_FULL = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(32'(y) * 32'(H_DISPLAY) + 32'(x));
  endfunction

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   addr_mem_r [FIFO_DEPTH];
  logic [DATA_W-1:0]   data_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_r, wr_ptr_r;
  logic [2:0]          level_r, level_nxt_s;
  logic                push_s, in_range_s, enq_s, drop_s, pop_s;
  logic                vo_d1_r, hs_d1_r, hs_d2_r, vs_d1_r, vs_d2_r;
  logic [DATA_W-1:0]   rgb_r;
  logic [15:0]         drop_cnt_r;

  assign wr_ready   = (level_r != LVL_FULL);
  assign push_s     = wr_valid && wr_ready;
  assign in_range_s = (32'(wr_x) < H_DISPLAY) && (32'(wr_y) < V_DISPLAY);
  assign enq_s      = push_s && in_range_s;
  assign drop_s     = push_s && !in_range_s;
  // Reset is folded in so a mid-drain reset never leaks a write onto the RAM port.
  assign pop_s      = reset_n && !video_on && (level_r != 3'd0);

  assign fifo_level = level_r;
  assign drop_count = drop_cnt_r;
  assign rgb        = rgb_r;
  assign hsync_out  = hs_d2_r;
  assign vsync_out  = vs_d2_r;

  // RAM port mux: scan-out read has absolute priority over queued writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (video_on) begin
      mem_addr = pix_addr(pixel_x, pixel_y);
    end else if (pop_s) begin
      mem_we    = 1'b1;
      mem_addr  = addr_mem_r[rd_ptr_r];
      mem_wdata = data_mem_r[rd_ptr_r];
    end else begin
      mem_we = 1'b0;
    end
  end

  // Occupancy after this cycle's enqueue/pop.
  always_comb begin
    level_nxt_s = level_r;
    case ({enq_s, pop_s})
      2'b10:   level_nxt_s = level_r + 3'd1;
      2'b01:   level_nxt_s = level_r - 3'd1;
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage; entries hold the precomputed RAM address.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_mem_r[wr_ptr_r] <= pix_addr(wr_x, wr_y);
      data_mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers and level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      level_r  <= 3'd0;
    end else begin
      if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r <= level_nxt_s;
    end
  end

  // Saturating count of out-of-range writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt_r <= 16'd0;
    end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  // Status FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (video_on)               state_nxt_s = ST_SCAN;
        else if (level_r != 3'd0)   state_nxt_s = ST_DRAIN;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (video_on)               state_nxt_s = ST_SCAN;
        else if (level_r != 3'd0)   state_nxt_s = ST_DRAIN;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (video_on)               state_nxt_s = ST_SCAN;
        else if (level_nxt_s == 3'd0) state_nxt_s = ST_IDLE;
        else                        state_nxt_s = ST_DRAIN;
      end
      default:                      state_nxt_s = ST_IDLE;
    endcase
  end

  // Status FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Two-stage alignment: RAM data arrives at N+1, colour and syncs leave at N+2.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vo_d1_r <= 1'b0;
      hs_d1_r <= 1'b1;
      hs_d2_r <= 1'b1;
      vs_d1_r <= 1'b1;
      vs_d2_r <= 1'b1;
      rgb_r   <= {DATA_W{1'b0}};
    end else begin
      vo_d1_r <= video_on;
      hs_d1_r <= hsync_in;
      hs_d2_r <= hs_d1_r;
      vs_d1_r <= vsync_in;
      vs_d2_r <= vs_d1_r;
      rgb_r   <= vo_d1_r ? mem_rdata : {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: RAM writes are scoreboarded in issue order,
// scan reads, sync alignment, drops and reset are checked directly.
module tb_vga_fb_arbiter;
  localparam int H  = 256;
  localparam int V  = 480;
  localparam int AW = 17;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset_n, video_on, hsync_in, vsync_in;
  logic [9:0]    pixel_x, pixel_y, wr_x, wr_y;
  logic          wr_valid, wr_ready, mem_we, hsync_out, vsync_out;
  logic [DW-1:0] wr_data, mem_wdata, mem_rdata, rgb;
  logic [AW-1:0] mem_addr;
  logic [15:0]   drop_count;
  logic [2:0]    fifo_level;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .reset_n(reset_n), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_x     = 10'(x);
    wr_y     = 10'(y);
    wr_data  = d;
    if (x < H && y < V) sb_q.push_back(wr_t'{addr: AW'(y * H + x), data: d});
    cyc();
    wr_valid = 1'b0;
  endtask

  // Write monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check_eq("wr_in_scan", 32'(video_on), 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("wr_unexpected", 32'(mem_we), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check_eq("wr_data", 32'(mem_wdata), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; wr_valid = 1'b0; wr_x = 10'd0; wr_y = 10'd0;
    wr_data = 3'd0; mem_rdata = 3'd0;
    repeat (2) cyc();
    reset_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge clk);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_rgb", 32'(rgb), 32'd0);
    check_eq("rst_hs", 32'(hsync_out), 32'd1);
    check_eq("rst_vs", 32'(vsync_out), 32'd1);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    cyc();

    // Single write during blanking.
    push(5, 2, 3'b101);
    @(negedge clk);
    check_eq("t1_we", 32'(mem_we), 32'd1);
    check_eq("t1_addr", 32'(mem_addr), 32'd517);
    check_eq("t1_wdata", 32'(mem_wdata), 32'd5);
    cyc();
    @(negedge clk);
    check_eq("t1_level", 32'(fifo_level), 32'd0);
    check_eq("t1_we_after", 32'(mem_we), 32'd0);
    cyc();

    // Fill during active video, then drain; a push offered while full is refused.
    video_on = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 3, 3'(i + 1));
    @(negedge clk);
    check_eq("t2_ready_full", 32'(wr_ready), 32'd0);
    check_eq("t2_level_full", 32'(fifo_level), 32'd4);
    check_eq("t2_we_scan", 32'(mem_we), 32'd0);
    cyc();
    video_on = 1'b0; wr_valid = 1'b1; wr_x = 10'd1; wr_y = 10'd1; wr_data = 3'd7;
    @(negedge clk);
    check_eq("t2_we_0", 32'(mem_we), 32'd1);
    check_eq("t2_ready_0", 32'(wr_ready), 32'd0);
    cyc();
    wr_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check_eq("t2_we_k", 32'(mem_we), 32'd1);
      check_eq("t2_ready_k", 32'(wr_ready), 32'd1);
      cyc();
    end
    @(negedge clk);
    check_eq("t2_we_done", 32'(mem_we), 32'd0);
    check_eq("t2_level_done", 32'(fifo_level), 32'd0);
    cyc();

    // Scan read latency, blank gating and sync alignment.
    video_on = 1'b1; pixel_x = 10'd10; pixel_y = 10'd1; hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk);
    check_eq("t3_addr", 32'(mem_addr), 32'd266);
    check_eq("t3_we", 32'(mem_we), 32'd0);
    check_eq("t3_hs_n0", 32'(hsync_out), 32'd1);
    cyc();
    mem_rdata = 3'b011; hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0;
    @(negedge clk);
    check_eq("t3_hs_n1", 32'(hsync_out), 32'd1);
    cyc();
    mem_rdata = 3'b110;
    @(negedge clk);
    check_eq("t3_rgb_n2", 32'(rgb), 32'd3);
    check_eq("t3_hs_n2", 32'(hsync_out), 32'd0);
    check_eq("t3_vs_n2", 32'(vsync_out), 32'd0);
    cyc();
    mem_rdata = 3'b000;
    @(negedge clk);
    check_eq("t3_rgb_blank", 32'(rgb), 32'd0);
    check_eq("t3_hs_n3", 32'(hsync_out), 32'd1);
    cyc();

    // Out-of-range writes and saturation.
    push(256, 0, 3'd1);
    push(0, 480, 3'd2);
    @(negedge clk);
    check_eq("t4_drop2", 32'(drop_count), 32'd2);
    check_eq("t4_level", 32'(fifo_level), 32'd0);
    cyc();
    wr_valid = 1'b1; wr_x = 10'd300; wr_y = 10'd0;
    repeat (65533) cyc();
    wr_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_drop_max", 32'(drop_count), 32'hFFFF);
    cyc();
    push(300, 0, 3'd0);
    @(negedge clk);
    check_eq("t4_drop_sat", 32'(drop_count), 32'hFFFF);
    check_eq("t4_ready", 32'(wr_ready), 32'd1);
    cyc();

    // Video resumes mid-drain: read takes the port, remainder drains next blanking.
    video_on = 1'b1; pixel_x = 10'd3; pixel_y = 10'd0;
    push(20, 4, 3'd1);
    push(21, 4, 3'd2);
    push(22, 4, 3'd3);
    video_on = 1'b0;
    @(negedge clk);
    check_eq("t5_pop1", 32'(mem_we), 32'd1);
    cyc();
    video_on = 1'b1;
    @(negedge clk);
    check_eq("t5_we_scan", 32'(mem_we), 32'd0);
    check_eq("t5_addr_scan", 32'(mem_addr), 32'd3);
    check_eq("t5_level2", 32'(fifo_level), 32'd2);
    cyc();
    @(negedge clk);
    check_eq("t5_level_hold", 32'(fifo_level), 32'd2);
    cyc();
    video_on = 1'b0;
    @(negedge clk);
    check_eq("t5_pop2", 32'(mem_we), 32'd1);
    cyc();
    @(negedge clk);
    check_eq("t5_pop3", 32'(mem_we), 32'd1);
    cyc();
    @(negedge clk);
    check_eq("t5_we_done", 32'(mem_we), 32'd0);
    check_eq("t5_level0", 32'(fifo_level), 32'd0);
    cyc();

    // Reset with entries queued discards them.
    video_on = 1'b1;
    push(40, 5, 3'd4);
    mem_rdata = 3'b111;
    push(41, 5, 3'd5);
    reset_n = 1'b0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk);
    check_eq("t6_we_in_rst", 32'(mem_we), 32'd0);
    sb_q.delete();
    cyc();
    reset_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; mem_rdata = 3'b000;
    @(negedge clk);
    check_eq("t6_level", 32'(fifo_level), 32'd0);
    check_eq("t6_rgb", 32'(rgb), 32'd0);
    check_eq("t6_hs", 32'(hsync_out), 32'd1);
    check_eq("t6_vs", 32'(vsync_out), 32'd1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t6_no_write", 32'(mem_we), 32'd0);
      cyc();
    end

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
